logic_preimage_finder: RTL and testbench

Sequential inverse of the team's 4-input / 2-output combinational function block. Given a target output pair {F1,F2}, it sweeps all 16 input vectors {A,B,C,D}, one per cycle, and streams every vector that produces the target over a valid/ready handshake. It then reports the total match count. It sits beside the forward function block as its exhaustive-search counterpart for lab checking and self-test.

---
 rtl/logic_preimage_finder_pkg.sv | 15 +
 rtl/logic_preimage_finder_eval.sv | 19 +
 rtl/logic_preimage_finder.sv | 102 ++++++++++
 tb/tb_logic_preimage_finder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/logic_preimage_finder_pkg.sv
// Shared definitions for the preimage finder: widths, sweep bound, FSM states.
package logic_preimage_finder_pkg;

  localparam int unsigned VEC_W = 4;
  localparam int unsigned CNT_W = 5;
  localparam logic [VEC_W-1:0] LAST_IDX = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_HOLD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/logic_preimage_finder_eval.sv
// Forward 4-in/2-out function: {A,B,C,D} -> {F1,F2}, purely combinational.
module logic_eval
  import logic_preimage_finder_pkg::*;
(
  input  logic [VEC_W-1:0] idx_i,
  output logic [1:0]       f_o
);

  logic a, b, c, d;

  assign {a, b, c, d} = idx_i;

  // Evaluate F1 (bit 1) and F2 (bit 0) from the input vector
  always_comb begin
    f_o[0] = d | (~a & b);
    f_o[1] = a | (~b & c) | ((~a & b) ^ d);
  end

endmodule

// File: rtl/logic_preimage_finder.sv
// Exhaustive-search inverse of logic_eval: sweeps all 16 input vectors and
// streams every vector whose output equals the captured target.
module logic_preimage_finder
  import logic_preimage_finder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       target,
  output logic             busy,
  output logic             match_valid,
  input  logic             match_ready,
  output logic [VEC_W-1:0] match_vec,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic [1:0]       target_q, target_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       f_cur;

  logic_eval u_eval (
    .idx_i (idx_q),
    .f_o   (f_cur)
  );

  // State, index, target, output vector and match counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      target_q <= '0;
      vec_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      target_q <= target_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic: one vector per SCAN cycle, HOLD until the match is taken
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    target_d = target_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          target_d = target;
          idx_d    = '0;
          cnt_d    = '0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (f_cur == target_q) begin
          vec_d   = idx_q;
          cnt_d   = cnt_q + 5'd1;
          state_d = ST_HOLD;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_HOLD: begin
        if (match_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state
  always_comb begin
    busy        = (state_q != ST_IDLE);
    match_valid = (state_q == ST_HOLD);
    done        = (state_q == ST_DONE);
    match_vec   = vec_q;
    match_count = cnt_q;
  end

endmodule

// File: tb/tb_logic_preimage_finder.sv
// Scoreboard bench for logic_preimage_finder: the stimulus pushes expected
// matches/counts into queues, a negedge monitor pops them on each transfer/done.
module tb_logic_preimage_finder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] target = 2'b00;
  logic       match_ready = 1'b0;
  logic       busy, match_valid, done;
  logic [3:0] match_vec;
  logic [4:0] match_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [3:0] exp_q[$];
  logic [4:0] exp_cnt_q[$];

  logic       prev_stalled = 1'b0;
  logic [3:0] prev_vec = '0;

  always #5 clk = ~clk;

  logic_preimage_finder dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .target      (target),
    .busy        (busy),
    .match_valid (match_valid),
    .match_ready (match_ready),
    .match_vec   (match_vec),
    .done        (done),
    .match_count (match_count)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  // Reference: does vector v produce output pair t? Written straight from the equations.
  function automatic bit model_hit(input logic [1:0] t, input int unsigned v);
    bit a, b, c, d, f1, f2;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    f2 = d || (!a && b);
    f1 = a || (!b && c) || ((!a && b) != d);
    return ({f1, f2} == t);
  endfunction

  // Push the expected ordered match list and count; returns the count
  function automatic int unsigned push_expect(input logic [1:0] t);
    int unsigned m = 0;
    for (int unsigned v = 0; v < 16; v++) begin
      if (model_hit(t, v)) begin
        exp_q.push_back(4'(v));
        m++;
      end
    end
    exp_cnt_q.push_back(5'(m));
    return m;
  endfunction

  // Monitor: sampled mid-cycle, inputs change just after posedge
  always @(negedge clk) begin
    if (rst) begin
      prev_stalled <= 1'b0;
    end else begin
      if (prev_stalled && match_valid)
        check("vec_stable_during_stall", match_vec, prev_vec);
      if (match_valid && match_ready) begin
        if (exp_q.size() == 0) check("unexpected_match", match_vec, 16);
        else check("match_vec", match_vec, exp_q.pop_front());
      end
      if (done) begin
        if (exp_cnt_q.size() == 0) check("unexpected_done", 1, 0);
        else check("match_count_at_done", match_count, exp_cnt_q.pop_front());
        check("all_matches_drained", exp_q.size(), 0);
      end
      prev_stalled <= match_valid && !match_ready;
      prev_vec     <= match_vec;
    end
  end

  // mode: 0 ready high, 1 random ready, 2 stall 10 cycles at first match,
  //       3 ready high with a spurious start/target change mid-sweep
  task automatic run_sweep(input logic [1:0] t, input int unsigned mode,
                           output logic [4:0] final_cnt);
    int unsigned m, edges, stall;
    bit seen_done;
    m = push_expect(t);
    stall = 0;
    seen_done = 0;
    @(posedge clk); #1;
    start = 1'b1; target = t;
    match_ready = (mode != 2);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    edges = 1;
    for (int unsigned i = 0; i < 300; i++) begin
      if (done) begin seen_done = 1; break; end
      case (mode)
        1: match_ready = 1'($urandom_range(0, 1));
        2: begin
          if (stall < 10 && match_valid) begin
            check("stall_vec_0001", match_vec, 4'b0001);
            match_ready = 1'b0;
            stall++;
          end else if (stall >= 10) match_ready = 1'b1;
        end
        3: begin
          start  = (edges == 4);
          target = (edges == 4) ? ~t : t;
        end
        default: match_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    if (!seen_done) begin
      check("sweep_timeout", 0, 1);
      exp_q.delete();
      exp_cnt_q.delete();
    end else if (mode == 0 || mode == 3) begin
      check("sweep_edges", edges, 17 + m);
    end
    final_cnt = match_count;
    @(posedge clk); #1;
    check("done_single_pulse", done, 0);
    check("busy_low_after_done", busy, 0);
    check("count_stable_after_done", match_count, final_cnt);
    match_ready = 1'b0;
  endtask

  initial begin
    logic [4:0] c;
    int unsigned sum;
    logic [1:0] rt;
    bit done_seen;

    #12;
    check("reset_busy", busy, 0);
    check("reset_valid", match_valid, 0);
    check("reset_vec", match_vec, 0);
    check("reset_done", done, 0);
    check("reset_count", match_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    sum = 0;
    run_sweep(2'b00, 0, c); check("count_t00", c, 1); sum += c;
    run_sweep(2'b01, 0, c); check("count_t01", c, 2); sum += c;
    run_sweep(2'b10, 1, c); check("count_t10", c, 5); sum += c;
    run_sweep(2'b11, 2, c); check("count_t11", c, 8); sum += c;
    check("count_sum_16", sum, 16);

    run_sweep(2'b10, 3, c); check("count_ignored_restart", c, 5);

    // Reset while a match is held: outputs clear immediately, no done
    void'(push_expect(2'b11));
    @(posedge clk); #1;
    start = 1'b1; target = 2'b11; match_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int unsigned i = 0; i < 20 && !match_valid; i++) begin
      @(posedge clk); #1;
    end
    check("hold_reached", match_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", match_valid, 0);
    check("rst_vec", match_vec, 0);
    check("rst_done", done, 0);
    check("rst_count", match_count, 0);
    exp_q.delete();
    exp_cnt_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) done_seen = 1;
    end
    check("no_done_after_rst", done_seen, 0);
    run_sweep(2'b11, 0, c); check("count_after_rst", c, 8);

    // Randomized targets and ready patterns
    for (int unsigned n = 0; n < 6; n++) begin
      rt = 2'($urandom_range(0, 3));
      run_sweep(rt, $urandom_range(0, 1), c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
